// File: rtl/pulp_io_padmux.sv
// pulp_io_padmux
// Routes any of NUM_PERIPH_SIG peripheral I/O slots onto any of NUM_PADS pads.
// Each pad owns a 32-bit config word (sel, sync_bypass, force_off, busy) written
// through a simple always-granted register port. Changing a pad's selection
// parks the pad in a GAP state with its output enable forced low for
// GAP_CYCLES cycles, so the old and new drivers never overlap on the pad.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   reg_req_i/we_i/addr_i/wdata_i register request (addr is the pad word index)
//   reg_gnt_o                    grant, equal to reg_req_i
//   reg_rvalid_o/rdata_o         response one cycle after every request
//   periph_o_i/periph_oe_i       per-slot peripheral output value / enable
//   periph_i_o                   per-slot input value delivered to peripherals
//   pad_o/pad_oe_o/pad_i         pad frame output value / enable / input value
//   switch_busy_o                per-pad flag, high while the pad is in GAP
module pulp_io_padmux #(
  parameter int NUM_PADS       = 32,
  parameter int NUM_PERIPH_SIG = 64,
  parameter int GAP_CYCLES     = 2,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      reg_req_i,
  input  logic                      reg_we_i,
  input  logic [7:0]                reg_addr_i,
  input  logic [31:0]               reg_wdata_i,
  output logic                      reg_gnt_o,
  output logic                      reg_rvalid_o,
  output logic [31:0]               reg_rdata_o,
  input  logic [NUM_PERIPH_SIG-1:0] periph_o_i,
  input  logic [NUM_PERIPH_SIG-1:0] periph_oe_i,
  output logic [NUM_PERIPH_SIG-1:0] periph_i_o,
  output logic [NUM_PADS-1:0]       pad_o,
  output logic [NUM_PADS-1:0]       pad_oe_o,
  input  logic [NUM_PADS-1:0]       pad_i,
  output logic [NUM_PADS-1:0]       switch_busy_o
);

  localparam int SEL_W = $clog2(NUM_PERIPH_SIG + 1);
  localparam int AW    = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1;
  localparam int CNT_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic {ST_ACTIVE = 1'b0, ST_GAP = 1'b1} state_e;

  // Selections beyond the last slot are treated as "pad off".
  function automatic logic [SEL_W-1:0] sanitize_sel(input logic [SEL_W-1:0] raw);
    if (raw > SEL_W'(NUM_PERIPH_SIG)) return '0;
    return raw;
  endfunction

  function automatic logic [31:0] cfg_word(input logic             gap,
                                           input logic [SEL_W-1:0] sel,
                                           input logic             byp,
                                           input logic             frc);
    logic [31:0] w;
    w              = '0;
    w[SEL_W-1:0]   = sel;
    w[16]          = byp;
    w[17]          = frc;
    w[31]          = gap;
    return w;
  endfunction

  state_e                 state_q    [NUM_PADS];
  state_e                 state_d    [NUM_PADS];
  logic [SEL_W-1:0]       cur_sel_q  [NUM_PADS];
  logic [SEL_W-1:0]       cur_sel_d  [NUM_PADS];
  logic [SEL_W-1:0]       pend_sel_q [NUM_PADS];
  logic [SEL_W-1:0]       pend_sel_d [NUM_PADS];
  logic [CNT_W-1:0]       cnt_q      [NUM_PADS];
  logic [CNT_W-1:0]       cnt_d      [NUM_PADS];
  logic [NUM_PADS-1:0]    byp_q, byp_d;
  logic [NUM_PADS-1:0]    frc_q, frc_d;
  logic [SYNC_STAGES-1:0] sync_q     [NUM_PADS];
  logic [SYNC_STAGES-1:0] sync_d     [NUM_PADS];
  logic                   rvalid_q, rvalid_d;
  logic [31:0]            rdata_q, rdata_d;

  logic                   addr_ok;
  logic [AW-1:0]          addr_idx;
  logic                   wr_en;
  logic [SEL_W-1:0]       wsel;
  logic [31:0]            rd_word;
  logic [NUM_PADS-1:0]    cond_in;

  // Config bits with no storage behind them.
  logic unused_wdata;
  assign unused_wdata = ^{reg_wdata_i[30:18], reg_wdata_i[15:SEL_W]};

  assign addr_ok  = (reg_addr_i < 8'(NUM_PADS));
  assign addr_idx = reg_addr_i[AW-1:0];
  assign wr_en    = reg_req_i && reg_we_i && addr_ok;
  assign wsel     = sanitize_sel(reg_wdata_i[SEL_W-1:0]);

  // ---- per-pad switch-over FSM and synchroniser next state ----
  always_comb begin
    for (int p = 0; p < NUM_PADS; p++) begin
      state_d[p]    = state_q[p];
      cur_sel_d[p]  = cur_sel_q[p];
      pend_sel_d[p] = pend_sel_q[p];
      cnt_d[p]      = cnt_q[p];
      byp_d[p]      = byp_q[p];
      frc_d[p]      = frc_q[p];
      sync_d[p]     = {sync_q[p][SYNC_STAGES-2:0], pad_i[p]};

      if (wr_en && (addr_idx == AW'(p))) begin
        byp_d[p] = reg_wdata_i[16];
        frc_d[p] = reg_wdata_i[17];
        // Any write during GAP restarts the gap, even back to the old route.
        if ((state_q[p] == ST_GAP) || (wsel != cur_sel_q[p])) begin
          state_d[p]    = ST_GAP;
          pend_sel_d[p] = wsel;
          cnt_d[p]      = CNT_W'(GAP_CYCLES - 1);
        end
      end else if (state_q[p] == ST_GAP) begin
        if (cnt_q[p] != '0) begin
          cnt_d[p] = cnt_q[p] - CNT_W'(1);
        end else begin
          cur_sel_d[p] = pend_sel_q[p];
          state_d[p]   = ST_ACTIVE;
        end
      end
    end
  end

  // ---- register read response ----
  always_comb begin
    rd_word = '0;
    for (int p = 0; p < NUM_PADS; p++) begin
      if (addr_idx == AW'(p)) begin
        rd_word = cfg_word(state_q[p] == ST_GAP,
                           (state_q[p] == ST_GAP) ? pend_sel_q[p] : cur_sel_q[p],
                           byp_q[p], frc_q[p]);
      end
    end
    rvalid_d = reg_req_i;
    rdata_d  = (reg_req_i && !reg_we_i && addr_ok) ? rd_word : '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int p = 0; p < NUM_PADS; p++) begin
        state_q[p]    <= ST_ACTIVE;
        cur_sel_q[p]  <= '0;
        pend_sel_q[p] <= '0;
        cnt_q[p]      <= '0;
        sync_q[p]     <= '0;
      end
      byp_q    <= '0;
      frc_q    <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      for (int p = 0; p < NUM_PADS; p++) begin
        state_q[p]    <= state_d[p];
        cur_sel_q[p]  <= cur_sel_d[p];
        pend_sel_q[p] <= pend_sel_d[p];
        cnt_q[p]      <= cnt_d[p];
        sync_q[p]     <= sync_d[p];
      end
      byp_q    <= byp_d;
      frc_q    <= frc_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  // ---- combinational pad output path from registered state ----
  always_comb begin
    for (int p = 0; p < NUM_PADS; p++) begin
      pad_o[p]         = 1'b0;
      pad_oe_o[p]      = 1'b0;
      switch_busy_o[p] = (state_q[p] == ST_GAP);
      cond_in[p]       = byp_q[p] ? pad_i[p] : sync_q[p][SYNC_STAGES-1];
      if ((state_q[p] == ST_ACTIVE) && !frc_q[p]) begin
        for (int k = 0; k < NUM_PERIPH_SIG; k++) begin
          if (cur_sel_q[p] == SEL_W'(k + 1)) begin
            pad_o[p]    = periph_o_i[k];
            pad_oe_o[p] = periph_oe_i[k];
          end
        end
      end
    end
  end

  // Walk pads from high to low so the lowest-index selecting pad wins.
  always_comb begin
    for (int j = 0; j < NUM_PERIPH_SIG; j++) begin
      periph_i_o[j] = 1'b0;
      for (int p = NUM_PADS - 1; p >= 0; p--) begin
        if ((state_q[p] == ST_ACTIVE) && (cur_sel_q[p] == SEL_W'(j + 1))) begin
          periph_i_o[j] = cond_in[p];
        end
      end
    end
  end

  assign reg_gnt_o    = reg_req_i;
  assign reg_rvalid_o = rvalid_q;
  assign reg_rdata_o  = rdata_q;

endmodule

// File: tb/tb_pulp_io_padmux.sv
module tb_pulp_io_padmux;
  localparam int NUM_PADS       = 32;
  localparam int NUM_PERIPH_SIG = 64;
  localparam int GAP_CYCLES     = 2;
  localparam int SYNC_STAGES    = 2;
  localparam int SEL_W          = $clog2(NUM_PERIPH_SIG + 1);

  logic                      clk = 1'b0;
  logic                      rst_i = 1'b1;
  logic                      reg_req_i = 1'b0;
  logic                      reg_we_i = 1'b0;
  logic [7:0]                reg_addr_i = '0;
  logic [31:0]               reg_wdata_i = '0;
  logic                      reg_gnt_o;
  logic                      reg_rvalid_o;
  logic [31:0]               reg_rdata_o;
  logic [NUM_PERIPH_SIG-1:0] periph_o_i = '0;
  logic [NUM_PERIPH_SIG-1:0] periph_oe_i = '0;
  logic [NUM_PERIPH_SIG-1:0] periph_i_o;
  logic [NUM_PADS-1:0]       pad_o;
  logic [NUM_PADS-1:0]       pad_oe_o;
  logic [NUM_PADS-1:0]       pad_i = '0;
  logic [NUM_PADS-1:0]       switch_busy_o;

  int n_vec = 0;
  int n_err = 0;

  pulp_io_padmux #(
    .NUM_PADS(NUM_PADS), .NUM_PERIPH_SIG(NUM_PERIPH_SIG),
    .GAP_CYCLES(GAP_CYCLES), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .reg_req_i(reg_req_i), .reg_we_i(reg_we_i), .reg_addr_i(reg_addr_i),
    .reg_wdata_i(reg_wdata_i), .reg_gnt_o(reg_gnt_o), .reg_rvalid_o(reg_rvalid_o),
    .reg_rdata_o(reg_rdata_o), .periph_o_i(periph_o_i), .periph_oe_i(periph_oe_i),
    .periph_i_o(periph_i_o), .pad_o(pad_o), .pad_oe_o(pad_oe_o), .pad_i(pad_i),
    .switch_busy_o(switch_busy_o)
  );

  always #5 clk = ~clk;

  // Reference model: per pad the visible route, the route it is heading to,
  // and how many forced-off cycles remain; pad input history as a delay line.
  int                  m_cur  [NUM_PADS];
  int                  m_pend [NUM_PADS];
  int                  m_gap  [NUM_PADS];
  bit                  m_byp  [NUM_PADS];
  bit                  m_frc  [NUM_PADS];
  bit [NUM_PADS-1:0]   m_hist [SYNC_STAGES];
  logic                exp_rvalid = 1'b0;
  logic [31:0]         exp_rdata = '0;

  function automatic logic [31:0] model_word(input int p);
    logic [31:0] w;
    w = 32'((m_gap[p] > 0) ? m_pend[p] : m_cur[p]);
    if (m_byp[p]) w = w | 32'h0001_0000;
    if (m_frc[p]) w = w | 32'h0002_0000;
    if (m_gap[p] > 0) w = w | 32'h8000_0000;
    return w;
  endfunction

  task automatic model_edge();
    int a;
    int sel;
    if (rst_i) begin
      for (int p = 0; p < NUM_PADS; p++) begin
        m_cur[p] = 0; m_pend[p] = 0; m_gap[p] = 0; m_byp[p] = 0; m_frc[p] = 0;
      end
      for (int s = 0; s < SYNC_STAGES; s++) m_hist[s] = '0;
      exp_rvalid = 1'b0;
      exp_rdata  = '0;
      return;
    end
    a = int'(reg_addr_i);
    exp_rvalid = reg_req_i;
    exp_rdata  = '0;
    if (reg_req_i && !reg_we_i && a < NUM_PADS) exp_rdata = model_word(a);
    for (int s = SYNC_STAGES - 1; s > 0; s--) m_hist[s] = m_hist[s-1];
    m_hist[0] = pad_i;
    for (int p = 0; p < NUM_PADS; p++) begin
      if (reg_req_i && reg_we_i && a == p) begin
        sel = int'(reg_wdata_i[SEL_W-1:0]);
        if (sel > NUM_PERIPH_SIG) sel = 0;
        m_byp[p] = reg_wdata_i[16];
        m_frc[p] = reg_wdata_i[17];
        if (m_gap[p] > 0 || sel != m_cur[p]) begin
          m_pend[p] = sel;
          m_gap[p]  = GAP_CYCLES;
        end
      end else if (m_gap[p] > 0) begin
        m_gap[p]--;
        if (m_gap[p] == 0) m_cur[p] = m_pend[p];
      end
    end
  endtask

  function automatic logic [NUM_PADS-1:0] exp_oe();
    logic [NUM_PADS-1:0] r;
    r = '0;
    for (int p = 0; p < NUM_PADS; p++)
      if (m_gap[p] == 0 && m_cur[p] != 0 && !m_frc[p]) r[p] = periph_oe_i[m_cur[p]-1];
    return r;
  endfunction

  function automatic logic [NUM_PADS-1:0] exp_po();
    logic [NUM_PADS-1:0] r;
    r = '0;
    for (int p = 0; p < NUM_PADS; p++)
      if (m_gap[p] == 0 && m_cur[p] != 0 && !m_frc[p]) r[p] = periph_o_i[m_cur[p]-1];
    return r;
  endfunction

  function automatic logic [NUM_PADS-1:0] exp_busy();
    logic [NUM_PADS-1:0] r;
    for (int p = 0; p < NUM_PADS; p++) r[p] = (m_gap[p] > 0);
    return r;
  endfunction

  function automatic logic [NUM_PERIPH_SIG-1:0] exp_pin();
    logic [NUM_PERIPH_SIG-1:0] r;
    bit claimed [NUM_PERIPH_SIG];
    r = '0;
    for (int j = 0; j < NUM_PERIPH_SIG; j++) claimed[j] = 0;
    for (int p = 0; p < NUM_PADS; p++) begin
      if (m_gap[p] == 0 && m_cur[p] != 0 && !claimed[m_cur[p]-1]) begin
        claimed[m_cur[p]-1] = 1;
        r[m_cur[p]-1] = m_byp[p] ? pad_i[p] : m_hist[SYNC_STAGES-1][p];
      end
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic reg_write(input int a, input logic [31:0] d);
    reg_req_i = 1'b1; reg_we_i = 1'b1; reg_addr_i = 8'(a); reg_wdata_i = d;
    tick();
    reg_req_i = 1'b0; reg_we_i = 1'b0;
  endtask

  task automatic reg_read(input int a);
    reg_req_i = 1'b1; reg_we_i = 1'b0; reg_addr_i = 8'(a);
    tick();
    reg_req_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    tick(); tick();
    rst_i = 1'b0;
    n_vec++; if (pad_oe_o !== '0) begin n_err++; $display("FAIL reset_pad_oe: got %h want 0", pad_oe_o); end
    n_vec++; if (pad_o !== '0) begin n_err++; $display("FAIL reset_pad_o: got %h want 0", pad_o); end
    n_vec++; if (periph_i_o !== '0) begin n_err++; $display("FAIL reset_periph_i: got %h want 0", periph_i_o); end
    n_vec++; if (switch_busy_o !== '0) begin n_err++; $display("FAIL reset_busy: got %h want 0", switch_busy_o); end
    n_vec++; if (reg_rvalid_o !== 1'b0) begin n_err++; $display("FAIL reset_rvalid: got %b want 0", reg_rvalid_o); end
    reg_read(3);
    n_vec++; if (reg_rvalid_o !== 1'b1) begin n_err++; $display("FAIL reset_read_rvalid: got %b want 1", reg_rvalid_o); end
    n_vec++; if (reg_rdata_o !== 32'h0) begin n_err++; $display("FAIL reset_read_pad3: got %h want 0", reg_rdata_o); end
  endtask

  task automatic test_routing_gap();
    periph_o_i  = {$urandom, $urandom};
    periph_oe_i = {$urandom, $urandom};
    periph_o_i[2] = 1'b1; periph_oe_i[2] = 1'b1;
    reg_write(5, 32'd3);
    n_vec++; if (switch_busy_o[5] !== 1'b1) begin n_err++; $display("FAIL gap_busy_t1: got %b want 1", switch_busy_o[5]); end
    n_vec++; if (pad_oe_o[5] !== 1'b0) begin n_err++; $display("FAIL gap_oe_t1: got %b want 0", pad_oe_o[5]); end
    tick();
    n_vec++; if (switch_busy_o[5] !== 1'b1) begin n_err++; $display("FAIL gap_busy_t2: got %b want 1", switch_busy_o[5]); end
    tick();
    n_vec++; if (switch_busy_o[5] !== 1'b0) begin n_err++; $display("FAIL gap_busy_t3: got %b want 0", switch_busy_o[5]); end
    n_vec++; if (pad_oe_o[5] !== 1'b1 || pad_o[5] !== 1'b1) begin n_err++; $display("FAIL gap_route_t3: got oe=%b o=%b want 1/1", pad_oe_o[5], pad_o[5]); end
    n_vec++; if (pad_oe_o !== exp_oe()) begin n_err++; $display("FAIL gap_oe_vec: got %h want %h", pad_oe_o, exp_oe()); end
    reg_read(5);
    n_vec++; if (reg_rdata_o !== 32'h3) begin n_err++; $display("FAIL gap_readback: got %h want 00000003", reg_rdata_o); end
  endtask

  task automatic test_rewrite_gap();
    periph_oe_i[5] = 1'b1;
    periph_o_i[5]  = 1'($urandom);
    reg_write(5, 32'd4);
    n_vec++; if (switch_busy_o[5] !== 1'b1) begin n_err++; $display("FAIL rewrite_busy_t1: got %b want 1", switch_busy_o[5]); end
    reg_write(5, 32'd6);
    n_vec++; if (switch_busy_o[5] !== 1'b1) begin n_err++; $display("FAIL rewrite_busy_t2: got %b want 1", switch_busy_o[5]); end
    tick();
    n_vec++; if (switch_busy_o[5] !== 1'b1) begin n_err++; $display("FAIL rewrite_busy_t3: got %b want 1", switch_busy_o[5]); end
    tick();
    n_vec++; if (switch_busy_o[5] !== 1'b0) begin n_err++; $display("FAIL rewrite_busy_t4: got %b want 0", switch_busy_o[5]); end
    n_vec++; if (pad_oe_o[5] !== 1'b1 || pad_o[5] !== periph_o_i[5]) begin n_err++; $display("FAIL rewrite_route_t4: got oe=%b o=%b want 1/%b", pad_oe_o[5], pad_o[5], periph_o_i[5]); end
    reg_read(5);
    n_vec++; if (reg_rdata_o !== 32'h6) begin n_err++; $display("FAIL rewrite_readback: got %h want 00000006", reg_rdata_o); end
  endtask

  task automatic test_sync_bypass();
    logic [NUM_PERIPH_SIG-1:0] e;
    pad_i[0] = 1'b0;
    reg_write(0, 32'd1);
    tick(); tick(); tick();
    pad_i[0] = 1'b1; #1;
    n_vec++; if (periph_i_o[0] !== 1'b0) begin n_err++; $display("FAIL sync_lat0: got %b want 0", periph_i_o[0]); end
    tick();
    n_vec++; if (periph_i_o[0] !== 1'b0) begin n_err++; $display("FAIL sync_lat1: got %b want 0", periph_i_o[0]); end
    tick();
    n_vec++; if (periph_i_o[0] !== 1'b1) begin n_err++; $display("FAIL sync_lat2: got %b want 1", periph_i_o[0]); end
    for (int i = 0; i < 10; i++) begin
      pad_i[0] = 1'($urandom); #1;
      e = exp_pin();
      n_vec++; if (periph_i_o[0] !== e[0]) begin n_err++; $display("FAIL sync_rand%0d: got %b want %b", i, periph_i_o[0], e[0]); end
      tick();
    end
    reg_write(0, 32'h0001_0001);
    n_vec++; if (switch_busy_o[0] !== 1'b0) begin n_err++; $display("FAIL bypass_no_gap: got %b want 0", switch_busy_o[0]); end
    for (int i = 0; i < 6; i++) begin
      pad_i[0] = ~pad_i[0]; #1;
      n_vec++; if (periph_i_o[0] !== pad_i[0]) begin n_err++; $display("FAIL bypass_follow%0d: got %b want %b", i, periph_i_o[0], pad_i[0]); end
      tick();
    end
  endtask

  task automatic test_shared_slot();
    pad_i[2] = 1'b0; pad_i[7] = 1'b1;
    reg_write(0, 32'd0);
    reg_write(2, 32'd1);
    reg_write(7, 32'd1);
    repeat (4) tick();
    n_vec++; if (periph_i_o[0] !== 1'b0) begin n_err++; $display("FAIL shared_in_lowest: got %b want 0", periph_i_o[0]); end
    for (int v = 0; v < 2; v++) begin
      periph_oe_i[0] = 1'(v); periph_o_i[0] = 1'($urandom); #1;
      n_vec++; if (pad_oe_o[2] !== 1'(v) || pad_oe_o[7] !== 1'(v)) begin n_err++; $display("FAIL shared_oe%0d: got %b%b want %0d%0d", v, pad_oe_o[2], pad_oe_o[7], v, v); end
      n_vec++; if (pad_o[2] !== periph_o_i[0] || pad_o[7] !== periph_o_i[0]) begin n_err++; $display("FAIL shared_o%0d: got %b%b want %b", v, pad_o[2], pad_o[7], periph_o_i[0]); end
    end
    reg_write(2, 32'd0);
    repeat (3) tick();
    n_vec++; if (periph_i_o[0] !== 1'b1) begin n_err++; $display("FAIL shared_handover: got %b want 1", periph_i_o[0]); end
  endtask

  task automatic test_illegal();
    reg_write(NUM_PADS, 32'h0000_0003);
    reg_read(NUM_PADS);
    n_vec++; if (reg_rvalid_o !== 1'b1 || reg_rdata_o !== 32'h0) begin n_err++; $display("FAIL oob_read: got v=%b d=%h want 1/0", reg_rvalid_o, reg_rdata_o); end
    reg_write(4, 32'(NUM_PERIPH_SIG + 1));
    reg_read(4);
    n_vec++; if (reg_rdata_o !== 32'h0) begin n_err++; $display("FAIL bad_sel_read: got %h want 0", reg_rdata_o); end
  endtask

  task automatic test_back_to_back();
    reg_write(9, 32'h0002_0007);
    reg_read(9);
    n_vec++; if (reg_rdata_o !== 32'h8002_0007) begin n_err++; $display("FAIL b2b_read: got %h want 80020007", reg_rdata_o); end
    reg_write(9, 32'h0000_0007);
    n_vec++; if (reg_rdata_o !== 32'h0 || reg_rvalid_o !== 1'b1) begin n_err++; $display("FAIL write_resp: got v=%b d=%h want 1/0", reg_rvalid_o, reg_rdata_o); end
  endtask

  task automatic test_reset_mid_gap();
    reg_write(4, 32'd2);
    n_vec++; if (switch_busy_o[4] !== 1'b1) begin n_err++; $display("FAIL midgap_busy_before: got %b want 1", switch_busy_o[4]); end
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    n_vec++; if (switch_busy_o !== '0) begin n_err++; $display("FAIL midgap_busy_after: got %h want 0", switch_busy_o); end
    n_vec++; if (pad_oe_o !== '0) begin n_err++; $display("FAIL midgap_oe_after: got %h want 0", pad_oe_o); end
    reg_read(4);
    n_vec++; if (reg_rdata_o !== 32'h0) begin n_err++; $display("FAIL midgap_sel_after: got %h want 0", reg_rdata_o); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      periph_o_i  = {$urandom, $urandom};
      periph_oe_i = {$urandom, $urandom};
      pad_i       = $urandom;
      reg_req_i   = 1'($urandom_range(0, 1));
      reg_we_i    = 1'($urandom_range(0, 1));
      reg_addr_i  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, NUM_PADS + 3))
                                                : 8'($urandom_range(0, 5));
      reg_wdata_i = $urandom;
      if ($urandom_range(0, 1) == 1) reg_wdata_i[6:0] = 7'($urandom_range(0, 8));
      #1;
      n_vec++; if (pad_oe_o !== exp_oe()) begin n_err++; $display("FAIL rnd_oe@%0d: got %h want %h", i, pad_oe_o, exp_oe()); end
      n_vec++; if (pad_o !== exp_po()) begin n_err++; $display("FAIL rnd_o@%0d: got %h want %h", i, pad_o, exp_po()); end
      n_vec++; if (switch_busy_o !== exp_busy()) begin n_err++; $display("FAIL rnd_busy@%0d: got %h want %h", i, switch_busy_o, exp_busy()); end
      n_vec++; if (periph_i_o !== exp_pin()) begin n_err++; $display("FAIL rnd_pin@%0d: got %h want %h", i, periph_i_o, exp_pin()); end
      n_vec++; if (reg_gnt_o !== reg_req_i) begin n_err++; $display("FAIL rnd_gnt@%0d: got %b want %b", i, reg_gnt_o, reg_req_i); end
      n_vec++; if (reg_rvalid_o !== exp_rvalid || reg_rdata_o !== exp_rdata) begin n_err++; $display("FAIL rnd_resp@%0d: got %b/%h want %b/%h", i, reg_rvalid_o, reg_rdata_o, exp_rvalid, exp_rdata); end
      tick();
    end
    reg_req_i = 1'b0;
    reg_we_i  = 1'b0;
  endtask

  initial begin
    test_reset();
    test_routing_gap();
    test_rewrite_gap();
    test_sync_bypass();
    test_shared_slot();
    test_illegal();
    test_back_to_back();
    test_reset_mid_gap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pulp_io_padmux.md
# pulp_io_padmux

Parametrised pad multiplexer that routes any of `NUM_PERIPH_SIG` peripheral I/O signals (UART, QSPI, I2C, CPI, DVSI, …) onto any of `NUM_PADS` physical pads. Pad selection is configured at runtime through a 32-bit register port. A per-pad switch-over state machine forces the pad's output enable low for a programmable gap, so no two drivers contend during re-selection. Input synchronisers on the pad-to-peripheral path can be bypassed per pad. The block sits between the peripheral subsystem's flattened `*_to_pad`/`pad_to_*` signals and the pad frame.

## Interface
- `NUM_PADS`, 32: number of physical pads (1..64).
- `NUM_PERIPH_SIG`, 64: number of peripheral signal slots (1..255).
- `GAP_CYCLES`, 2: forced-off cycles on re-selection (≥1).
- `SYNC_STAGES`, 2: input synchroniser depth (≥2).
- Derived: `SEL_W = $clog2(NUM_PERIPH_SIG+1)`; `AW = $clog2(NUM_PADS)`, minimum 1.

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: reset. Synchronous, active-high.
- `reg_req_i` in 1: register access request.
- `reg_we_i` in 1: 1 = write, 0 = read.
- `reg_addr_i` in 8: word index.
- `reg_wdata_i` in 32: write data.
- `reg_gnt_o` out 1: grant.
- `reg_rvalid_o` out 1: response valid.
- `reg_rdata_o` out 32: read data.
- `periph_o_i` in NUM_PERIPH_SIG: peripheral output values.
- `periph_oe_i` in NUM_PERIPH_SIG: peripheral output enables.
- `periph_i_o` out NUM_PERIPH_SIG: pad input values delivered to peripherals.
- `pad_o` out NUM_PADS: pad output values.
- `pad_oe_o` out NUM_PADS: pad output enables.
- `pad_i` in NUM_PADS: pad input values.
- `switch_busy_o` out NUM_PADS: pad is in its switch gap.

## Operation
- **Per-pad config register** at word index p < NUM_PADS:
  - `[SEL_W-1:0]` sel: 0 = pad off; k = peripheral slot k-1.
  - `[16]` sync_bypass.
  - `[17]` force_off: pad_oe held 0, input path unaffected.
  - `[31]` busy: read-only.
  - All other bits read 0.
  - A sel value > NUM_PERIPH_SIG is stored as 0.
- **Register port:**
  - `reg_gnt_o = reg_req_i` (always granted).
  - `reg_rvalid_o` pulses 1 the cycle after every granted request, reads and writes alike.
  - `reg_rdata_o` holds read data in that cycle and is 0 otherwise and for writes.
  - Address ≥ NUM_PADS: write ignored, read returns 0.
  - Read data returns the committed sel while ACTIVE and the pending sel while in GAP.
- **Per-pad FSM, states ACTIVE and GAP:**
  - ACTIVE, write with a new sel different from cur_sel → GAP:
    - pending_sel ← new sel.
    - cnt ← GAP_CYCLES-1.
    - sync_bypass and force_off update immediately.
  - ACTIVE, write with the same sel: only the bypass/force_off bits update; state stays ACTIVE.
  - GAP, cnt > 0: decrement cnt.
  - GAP, cnt == 0: cur_sel ← pending_sel, → ACTIVE.
  - GAP, new write to the same pad: pending_sel ← new sel, cnt reloads to GAP_CYCLES-1. The gap restarts even if the new sel equals the old cur_sel.
- **Output path:**
  - When ACTIVE, cur_sel = k ≠ 0 and force_off = 0: `pad_o = periph_o_i[k-1]` and `pad_oe_o = periph_oe_i[k-1]`.
  - Otherwise `pad_o = 0` and `pad_oe_o = 0`.
  - This path is combinational from the registered state.
- **Input path:**
  - Each pad has a SYNC_STAGES flop chain on `pad_i`, reset value 0. sync_bypass selects the raw `pad_i`.
  - `periph_i_o[j]` = conditioned input of the lowest-index ACTIVE pad with cur_sel = j+1.
  - If no ACTIVE pad selects slot j, `periph_i_o[j]` = 0.
  - A pad in GAP contributes to no slot.
- **Multiple pads on one slot:** every selecting pad drives the output; only the lowest-index pad feeds the input.
- `switch_busy_o[p]` = 1 exactly while pad p is in GAP.

## Timing
- **Reset:**
  - All pads ACTIVE with cur_sel = 0, sync_bypass = 0, force_off = 0.
  - `pad_o`, `pad_oe_o`, `periph_i_o`, `switch_busy_o`, `reg_rvalid_o` and `reg_rdata_o` are all 0.
  - Synchroniser flops are 0.
  - Reset asserted mid-GAP abandons pending_sel.
- **Write latency:** write accepted in cycle t (pad was ACTIVE, sel changes):
  - `pad_oe_o` is 0 and `switch_busy_o` is 1 for cycles t+1 … t+GAP_CYCLES.
  - The new route drives from cycle t+GAP_CYCLES+1.
- A bypass/force_off-only write takes effect at t+1.
- **Input latency:** SYNC_STAGES cycles from `pad_i` to `periph_i_o` when synchronised; 0 cycles when bypassed.
- **Read latency:** data for a read in cycle t appears at t+1 and reflects state after any write in cycle t-1.
- Back-to-back requests are allowed every cycle.

## Test plan
- **Reset defaults:** assert `rst_i` for 2 cycles. Expect all `pad_oe_o` = 0, all `periph_i_o` = 0, and a read of pad 3 returning 0x0 one cycle after the request.
- **Routing with gap:** write pad 5 sel=3 with `periph_oe_i[2]`=1 and `periph_o_i[2]`=1 (GAP_CYCLES=2). Expect `switch_busy_o[5]`=1 at t+1..t+2, `pad_oe_o[5]`=1 and `pad_o[5]`=1 from t+3, and a read returning 0x3.
- **Re-write during gap:** write pad 5 sel=4 at t, then sel=6 at t+1. Expect busy at t+1..t+3 and the slot-5 route active at t+4.
- **Input synchroniser and bypass:** with pad 0 sel=1, toggle `pad_i[0]`. Expect `periph_i_o[0]` to follow after 2 cycles; after writing bit16=1, it follows in the same cycle.
- **Shared slot:** pads 2 and 7 both select slot 1, with `pad_i[2]`=0 and `pad_i[7]`=1. Expect `periph_i_o[0]`=0 after sync, and `pad_oe_o[2]` and `pad_oe_o[7]` both following `periph_oe_i[0]`.
- **Illegal accesses and reset mid-gap:**
  - Write address NUM_PADS, then read it back: expect 0.
  - Write sel=NUM_PERIPH_SIG+1: expect a readback of 0.
  - Assert `rst_i` during a GAP: expect busy=0 and sel=0 on the next cycle.
